// File: rtl/skill_pkg.sv
// Shared types and helpers for the skill manager: slot state encoding,
// skill index constants and the point-to-LED thermometer decode.
package skill_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COOLDOWN = 2'd2
  } slot_state_t;

  localparam int SKILL_J    = 0;
  localparam int SKILL_K    = 1;
  localparam int SKILL_L    = 2;
  localparam int NUM_SKILLS = 3;

  // Thermometer code shown on the LED bar, filled from the MSB side
  function automatic logic [2:0] therm_led(input logic [1:0] points);
    logic [2:0] led;
    case (points)
      2'd0:    led = 3'b000;
      2'd1:    led = 3'b100;
      2'd2:    led = 3'b110;
      default: led = 3'b111;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/skill_manager_if.sv
// Skill request/response bundle between the keyboard/game side (master)
// and the skill manager (slave).
interface skill_manager_if;
  logic       tick;
  logic       game_active;
  logic [2:0] skill_req;
  logic       life_lost;
  logic [2:0] skill_remain;
  logic [2:0] skill_grant;
  logic       skill_reject;
  logic [1:0] skill_point;
  logic [2:0] skill_led;

  modport master (
    output tick, game_active, skill_req, life_lost,
    input  skill_remain, skill_grant, skill_reject, skill_point, skill_led
  );

  modport slave (
    input  tick, game_active, skill_req, life_lost,
    output skill_remain, skill_grant, skill_reject, skill_point, skill_led
  );
endinterface

// File: rtl/skill_slot.sv
// One skill slot: IDLE -> ACTIVE (dur ticks) -> COOLDOWN (CD_TICKS ticks) -> IDLE.
// clear forces IDLE (game left the stage); cancel cuts ACTIVE short into COOLDOWN.
module skill_slot
  import skill_pkg::*;
#(
  parameter int CNT_W    = 10,
  parameter int CD_TICKS = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             grant,
  input  logic             cancel,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] dur,
  output logic             idle,
  output logic             active
);

  slot_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Slot FSM with counter; idle/active are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idle      <= 1'b1;
      active    <= 1'b0;
    end else if (clear) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idle      <= 1'b1;
      active    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant) begin
            state_reg <= ACTIVE;
            cnt_reg   <= dur;
            idle      <= 1'b0;
            active    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cancel || (tick && cnt_reg == CNT_W'(1))) begin
            state_reg <= COOLDOWN;
            cnt_reg   <= CNT_W'(CD_TICKS);
            active    <= 1'b0;
          end else if (tick) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        COOLDOWN: begin
          if (tick) begin
            if (cnt_reg == CNT_W'(1)) begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
              idle      <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          idle      <= 1'b1;
          active    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/skill_manager.sv
// Skill manager top: request arbitration, point budget with periodic refill,
// game_active edge detection and three skill slots.
module skill_manager
  import skill_pkg::*;
#(
  parameter int MAX_POINTS   = 3,
  parameter int DUR0         = 100,
  parameter int DUR1         = 100,
  parameter int DUR2         = 60,
  parameter int CD_TICKS     = 40,
  parameter int REFILL_TICKS = 600,
  parameter int CNT_W        = 10
) (
  input logic             clk,
  input logic             rst_n,
  skill_manager_if.slave  bus
);

  localparam logic [1:0] MAX_PT = 2'(MAX_POINTS);

  logic [NUM_SKILLS-1:0] slot_idle;
  logic [NUM_SKILLS-1:0] slot_active;
  logic [NUM_SKILLS-1:0] grant_vec;
  logic                  grant_any;
  logic                  can_grant;
  logic                  clear_slots;
  logic                  game_active_d;
  logic                  game_rise;
  logic                  refill_fire;
  logic [1:0]            point_reg;
  logic [1:0]            point_next;
  logic [CNT_W-1:0]      refill_cnt_reg;
  logic [CNT_W-1:0]      refill_cnt_next;

  assign clear_slots = ~bus.game_active;
  assign game_rise   = bus.game_active & ~game_active_d;
  assign can_grant   = bus.game_active & (point_reg != 2'd0) & ~bus.life_lost;

  // Fixed-priority arbitration: lowest acceptable index wins
  always_comb begin
    logic found;
    grant_vec = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_SKILLS; i++) begin
      if (!found && can_grant && bus.skill_req[i] && slot_idle[i]) begin
        grant_vec[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign grant_any = |grant_vec;

  // Refill counter advances on tick only while a point is missing
  always_comb begin
    refill_cnt_next = refill_cnt_reg;
    refill_fire     = 1'b0;
    if (!bus.game_active || point_reg >= MAX_PT) begin
      refill_cnt_next = '0;
    end else if (bus.tick) begin
      if (refill_cnt_reg == CNT_W'(REFILL_TICKS - 1)) begin
        refill_cnt_next = '0;
        refill_fire     = 1'b1;
      end else begin
        refill_cnt_next = refill_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Point budget: reload on game start, then grant/refill adjust (cancel out if both)
  always_comb begin
    point_next = game_rise ? MAX_PT : point_reg;
    if (grant_any && !refill_fire) begin
      point_next = point_next - 2'd1;
    end else if (refill_fire && !grant_any) begin
      point_next = point_next + 2'd1;
    end
  end

  // Registered outputs and top-level state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      game_active_d    <= 1'b0;
      point_reg        <= MAX_PT;
      refill_cnt_reg   <= '0;
      bus.skill_grant  <= '0;
      bus.skill_reject <= 1'b0;
      bus.skill_led    <= therm_led(MAX_PT);
    end else begin
      game_active_d    <= bus.game_active;
      point_reg        <= point_next;
      refill_cnt_reg   <= refill_cnt_next;
      bus.skill_grant  <= grant_vec;
      bus.skill_reject <= |(bus.skill_req & ~grant_vec);
      bus.skill_led    <= therm_led(point_next);
    end
  end

  assign bus.skill_point  = point_reg;
  assign bus.skill_remain = slot_active;

  for (genvar gi = 0; gi < NUM_SKILLS; gi++) begin : g_slot
    localparam int DUR = (gi == SKILL_J) ? DUR0 : (gi == SKILL_K) ? DUR1 : DUR2;

    skill_slot #(
      .CNT_W    (CNT_W),
      .CD_TICKS (CD_TICKS)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .grant  (grant_vec[gi]),
      .cancel (bus.life_lost),
      .clear  (clear_slots),
      .tick   (bus.tick),
      .dur    (CNT_W'(DUR)),
      .idle   (slot_idle[gi]),
      .active (slot_active[gi])
    );
  end

endmodule

// File: tb/tb_skill_manager.sv
// Directed bench for skill_manager: grant/expiry, priority, life loss,
// refill, game_active toggling and asynchronous reset.
module tb_skill_manager;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  skill_manager_if bus ();

  skill_manager dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    bus.tick = 1'b1;
    repeat (n) step();
    bus.tick = 1'b0;
  endtask

  task automatic request(input logic [2:0] req);
    bus.skill_req = req;
    step();
    bus.skill_req = 3'b000;
  endtask

  task automatic restart();
    bus.game_active = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    bus.game_active = 1'b1;
    step();
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.tick        = 1'b0;
    bus.game_active = 1'b0;
    bus.skill_req   = 3'b000;
    bus.life_lost   = 1'b0;
    step();

    // Reset state
    check("rst_remain", 8'(bus.skill_remain), 8'h0);
    check("rst_grant",  8'(bus.skill_grant),  8'h0);
    check("rst_reject", 8'(bus.skill_reject), 8'h0);
    check("rst_point",  8'(bus.skill_point),  8'd3);
    check("rst_led",    8'(bus.skill_led),    8'b111);
    rst_n = 1'b1;
    step();
    bus.game_active = 1'b1;
    step();

    // 1: grant, 100-tick active, 40-tick cooldown, re-grant
    request(3'b001);
    check("t1_grant",  8'(bus.skill_grant),  8'b001);
    check("t1_remain", 8'(bus.skill_remain), 8'b001);
    check("t1_point",  8'(bus.skill_point),  8'd2);
    check("t1_led",    8'(bus.skill_led),    8'b110);
    step();
    check("t1_grant_pulse", 8'(bus.skill_grant), 8'b000);
    run_ticks(99);
    check("t1_remain_99", 8'(bus.skill_remain), 8'b001);
    run_ticks(1);
    check("t1_remain_100", 8'(bus.skill_remain), 8'b000);
    run_ticks(39);
    request(3'b001);
    check("t1_cd_reject", 8'(bus.skill_reject), 8'h1);
    check("t1_cd_nogrant", 8'(bus.skill_grant), 8'b000);
    run_ticks(1);
    request(3'b001);
    check("t1_regrant", 8'(bus.skill_grant), 8'b001);
    check("t1_regrant_point", 8'(bus.skill_point), 8'd1);

    // 2: priority among simultaneous requests, drain points
    restart();
    request(3'b111);
    check("t2_grant",  8'(bus.skill_grant),  8'b001);
    check("t2_reject", 8'(bus.skill_reject), 8'h1);
    check("t2_point",  8'(bus.skill_point),  8'd2);
    request(3'b010);
    check("t2_grant_k", 8'(bus.skill_grant), 8'b010);
    check("t2_noreject_k", 8'(bus.skill_reject), 8'h0);
    request(3'b100);
    check("t2_grant_l", 8'(bus.skill_grant), 8'b100);
    check("t2_point0",  8'(bus.skill_point), 8'd0);
    check("t2_led0",    8'(bus.skill_led),   8'b000);
    check("t2_remain_all", 8'(bus.skill_remain), 8'b111);
    run_ticks(140);
    check("t2_remain_done", 8'(bus.skill_remain), 8'b000);
    request(3'b001);
    check("t2_zero_reject", 8'(bus.skill_reject), 8'h1);
    check("t2_zero_nogrant", 8'(bus.skill_grant), 8'b000);
    check("t2_zero_point", 8'(bus.skill_point), 8'd0);

    // 3: life lost cancels active skill and beats a same-cycle request
    restart();
    request(3'b100);
    check("t3_grant", 8'(bus.skill_grant), 8'b100);
    run_ticks(30);
    check("t3_remain_mid", 8'(bus.skill_remain), 8'b100);
    bus.life_lost = 1'b1;
    request(3'b010);
    bus.life_lost = 1'b0;
    check("t3_remain_cut", 8'(bus.skill_remain), 8'b000);
    check("t3_reject",     8'(bus.skill_reject), 8'h1);
    check("t3_nogrant",    8'(bus.skill_grant),  8'b000);
    check("t3_point",      8'(bus.skill_point),  8'd2);
    run_ticks(39);
    request(3'b100);
    check("t3_cd_reject", 8'(bus.skill_reject), 8'h1);
    run_ticks(1);
    request(3'b100);
    check("t3_after_cd", 8'(bus.skill_grant), 8'b100);
    check("t3_after_cd_point", 8'(bus.skill_point), 8'd1);

    // 4: refill after 600 ticks; grant on the refill tick nets zero
    restart();
    request(3'b001);
    check("t4_point2", 8'(bus.skill_point), 8'd2);
    run_ticks(599);
    check("t4_599", 8'(bus.skill_point), 8'd2);
    run_ticks(1);
    check("t4_refill", 8'(bus.skill_point), 8'd3);
    check("t4_refill_led", 8'(bus.skill_led), 8'b111);
    request(3'b001);
    check("t4_point2b", 8'(bus.skill_point), 8'd2);
    run_ticks(599);
    bus.tick = 1'b1;
    request(3'b001);
    bus.tick = 1'b0;
    check("t4_same_grant", 8'(bus.skill_grant), 8'b001);
    check("t4_same_point", 8'(bus.skill_point), 8'd2);
    check("t4_same_led",   8'(bus.skill_led),   8'b110);
    run_ticks(600);
    check("t4_second_refill", 8'(bus.skill_point), 8'd3);

    // 5: game_active drop clears slots; rise reloads points
    restart();
    request(3'b010);
    check("t5_grant", 8'(bus.skill_grant), 8'b010);
    run_ticks(10);
    bus.game_active = 1'b0;
    step();
    check("t5_drop_remain", 8'(bus.skill_remain), 8'b000);
    request(3'b001);
    check("t5_inactive_reject", 8'(bus.skill_reject), 8'h1);
    bus.game_active = 1'b1;
    step();
    check("t5_rise_point", 8'(bus.skill_point), 8'd3);
    check("t5_rise_led",   8'(bus.skill_led),   8'b111);
    request(3'b010);
    check("t5_slot_idle", 8'(bus.skill_grant), 8'b010);

    // 6: asynchronous reset mid-ACTIVE, no clock edge needed
    run_ticks(5);
    check("t6_pre_remain", 8'(bus.skill_remain), 8'b010);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_remain", 8'(bus.skill_remain), 8'b000);
    check("t6_async_point",  8'(bus.skill_point),  8'd3);
    check("t6_async_led",    8'(bus.skill_led),    8'b111);
    step();
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
